gost_core_arbiter: RTL

- Shares one criptografia_GOST core (64-bit block, 256-bit key, 32 rounds) between N independent requesters.
- For each winning request it latches that requester's operands and issues a single-cycle start. It then waits for the core's ready pulse and returns the result with a per-requester done pulse.
- A watchdog terminates jobs whose core never answers.
- Sits between the upper-level block/mode sequencers and the single GOST core instance.

---
 rtl/gost_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 29 ++
 rtl/gost_core_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/gost_pkg.sv
// Shared widths, FSM encoding and operand slicing helpers for the GOST core arbiter.
package gost_pkg;

  localparam int GOST_BLOCK_W = 64;
  localparam int GOST_KEY_W   = 256;
  localparam int MAX_REQ      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } gost_state_e;

  // Callers zero-extend their packed vectors to MAX_REQ slices so one helper serves any N.
  function automatic logic [GOST_BLOCK_W-1:0] get_block(
    input logic [GOST_BLOCK_W*MAX_REQ-1:0] vec,
    input logic [2:0]                      k
  );
    return vec[k*GOST_BLOCK_W +: GOST_BLOCK_W];
  endfunction

  function automatic logic [GOST_KEY_W-1:0] get_key(
    input logic [GOST_KEY_W*MAX_REQ-1:0] vec,
    input logic [2:0]                    k
  );
    return vec[k*GOST_KEY_W +: GOST_KEY_W];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, in cyclic order.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any_grant && req[IW'(j)]) begin
        any_grant        = 1'b1;
        grant_idx        = IW'(j);
        grant[IW'(j)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gost_core_arbiter.sv
// Shares one GOST core between N_REQ requesters: round-robin grant, single-cycle start,
// result return with per-requester done pulse, watchdog abort when the core never answers.
module gost_core_arbiter
  import gost_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ-1:0]            enc_dec_i,
  input  logic [GOST_BLOCK_W*N_REQ-1:0] data_i,
  input  logic [GOST_KEY_W*N_REQ-1:0] key_i,
  output logic [N_REQ-1:0]            ack_o,
  output logic [N_REQ-1:0]            done_o,
  output logic [GOST_BLOCK_W-1:0]     data_o,
  output logic                        err_o,
  output logic                        busy_o,
  output logic                        core_start_o,
  output logic                        core_enc_dec_o,
  output logic [GOST_BLOCK_W-1:0]     core_data_o,
  output logic [GOST_KEY_W-1:0]       core_key_o,
  input  logic                        core_busy_i,
  input  logic                        core_ready_i,
  input  logic [GOST_BLOCK_W-1:0]     core_data_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC);

  gost_state_e             state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           gidx_q, gidx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    enc_q, enc_d;
  logic [GOST_BLOCK_W-1:0] cdata_q, cdata_d;
  logic [GOST_KEY_W-1:0]   ckey_q, ckey_d;
  logic [GOST_BLOCK_W-1:0] res_q, res_d;
  logic                    err_q, err_d;
  logic                    start_q, start_d;
  logic [N_REQ-1:0]        ack_q, ack_d;
  logic [N_REQ-1:0]        done_q, done_d;

  logic [N_REQ-1:0]        grant;
  logic [IW-1:0]           grant_idx;
  logic                    any_grant;

  logic [GOST_BLOCK_W*MAX_REQ-1:0] data_ext;
  logic [GOST_KEY_W*MAX_REQ-1:0]   key_ext;
  logic                            unused_busy;

  assign data_ext    = (GOST_BLOCK_W*MAX_REQ)'(data_i);
  assign key_ext     = (GOST_KEY_W*MAX_REQ)'(key_i);
  assign unused_busy = core_busy_i;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
    .req       (req_i),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    enc_d   = enc_q;
    cdata_d = cdata_q;
    ckey_d  = ckey_q;
    res_d   = res_q;
    err_d   = err_q;
    start_d = 1'b0;
    ack_d   = '0;
    done_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (any_grant) begin
          gidx_d  = grant_idx;
          enc_d   = enc_dec_i[grant_idx];
          cdata_d = get_block(data_ext, 3'(grant_idx));
          ckey_d  = get_key(key_ext, 3'(grant_idx));
          ptr_d   = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + IW'(1);
          ack_d   = grant;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // The ISSUE cycle counts toward the watchdog, so an abort lands TIMEOUT_CYC cycles after start.
        cnt_d   = cnt_q + CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (core_ready_i) begin
          res_d   = core_data_i;
          err_d   = 1'b0;
          done_d  = N_REQ'(1) << gidx_q;
          state_d = DONE;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          done_d  = N_REQ'(1) << gidx_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      enc_q   <= 1'b0;
      cdata_q <= '0;
      ckey_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      enc_q   <= enc_d;
      cdata_q <= cdata_d;
      ckey_q  <= ckey_d;
      res_q   <= res_d;
      err_q   <= err_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign ack_o          = ack_q;
  assign done_o         = done_q;
  assign data_o         = res_q;
  assign err_o          = err_q;
  assign busy_o         = (state_q != IDLE);
  assign core_start_o   = start_q;
  assign core_enc_dec_o = enc_q;
  assign core_data_o    = cdata_q;
  assign core_key_o     = ckey_q;

endmodule
